// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM state encoding and port indices.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single SRAM controller, one transaction at a time.
// Define SRAM_ARB_RR_EN for round-robin on simultaneous requests; otherwise port 0 has fixed priority.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0,
   input  logic                we0,
   input  logic [ADDR_W-1:0]   addr0,
   input  logic [DATA_W/8-1:0] be0,
   input  logic [DATA_W-1:0]   wdata0,
   input  logic                req1,
   input  logic                we1,
   input  logic [ADDR_W-1:0]   addr1,
   input  logic [DATA_W/8-1:0] be1,
   input  logic [DATA_W-1:0]   wdata1,
   output logic                ack0,
   output logic [DATA_W-1:0]   rdata0,
   output logic                ack1,
   output logic [DATA_W-1:0]   rdata1,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_busy
);

   state_t                state_q, state_d;
   logic                  grant;
   logic                  win_d;
   logic                  winner_q;
   logic                  mem_we_q;
   logic [ADDR_W-1:0]     mem_addr_q;
   logic [DATA_W/8-1:0]   mem_be_q;
   logic [DATA_W-1:0]     mem_wdata_q;
   logic [DATA_W-1:0]     rdata0_q, rdata1_q;
   logic                  complete;

`ifdef SRAM_ARB_RR_EN
   logic last_q;

   // On a tie the port that was not served last wins; a lone request always wins.
   always_comb begin
      win_d = req0 ? PORT_CPU : PORT_DMA;
      if (req0 && req1) begin
         win_d = (last_q == PORT_CPU) ? PORT_DMA : PORT_CPU;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= PORT_DMA;
      end else if (grant) begin
         last_q <= win_d;
      end
   end
`else
   assign win_d = req0 ? PORT_CPU : PORT_DMA;
`endif

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               grant   = 1'b1;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (!mem_busy) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign complete = (state_q == ACCESS) && !mem_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         winner_q    <= PORT_CPU;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         state_q <= state_d;
         // Command is frozen at grant so requester-side changes cannot disturb the access.
         if (grant) begin
            winner_q    <= win_d;
            mem_we_q    <= (win_d == PORT_CPU) ? we0    : we1;
            mem_addr_q  <= (win_d == PORT_CPU) ? addr0  : addr1;
            mem_be_q    <= (win_d == PORT_CPU) ? be0    : be1;
            mem_wdata_q <= (win_d == PORT_CPU) ? wdata0 : wdata1;
         end
         if (complete && !mem_we_q) begin
            if (winner_q == PORT_CPU) begin
               rdata0_q <= mem_rdata;
            end else begin
               rdata1_q <= mem_rdata;
            end
         end
      end
   end

   assign mem_en    = (state_q == ACCESS);
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign ack0      = (state_q == DONE) && (winner_q == PORT_CPU);
   assign ack1      = (state_q == DONE) && (winner_q == PORT_DMA);
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: per-scenario tasks, expected completions held in a scoreboard queue.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [19:0] addr0 = '0, addr1 = '0;
   logic [3:0]  be0 = '0, be1 = '0;
   logic [31:0] wdata0 = '0, wdata1 = '0;
   logic        ack0, ack1;
   logic [31:0] rdata0, rdata1;
   logic        mem_en, mem_we;
   logic [19:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_busy = 1'b0;

   typedef struct {
      int          port;
      bit          rd;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] rdata0_m = '0;
   logic [31:0] rdata1_m = '0;

   always #5 clk = ~clk;

   sram_arbiter #(.ADDR_W(20), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .be0(be0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .be1(be1), .wdata1(wdata1),
      .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy)
   );

   // Observes negedges until an ack appears; port = -1 when the budget expires.
   task automatic wait_ack(input int budget, output int port, output int cycles, output bit dual);
      port   = -1;
      cycles = 0;
      dual   = 1'b0;
      while (cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (ack0 && ack1) dual = 1'b1;
         if (ack0 || ack1) begin
            port = ack1 ? 1 : 0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      vectors++;
      if ({mem_en, mem_we, mem_addr, mem_be, mem_wdata, ack0, ack1, rdata0, rdata1} !== '0) begin
         miscompares++;
         $display("FAIL reset_async: got en=%b we=%b addr=%h be=%h wd=%h ack=%b%b rd0=%h rd1=%h expected all zero",
                  mem_en, mem_we, mem_addr, mem_be, mem_wdata, ack0, ack1, rdata0, rdata1);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({mem_en, ack0, ack1} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_idle: got en=%b ack=%b%b expected 000", mem_en, ack0, ack1);
      end
      $display("txn reset: done");
   endtask

   task automatic test_write();
      exp_t e;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 20'h00010; be0 = 4'hF; wdata0 = 32'hDEADBEEF; mem_busy = 1'b0;
      exp_q.push_back('{0, 1'b0, 32'h0});
      @(negedge clk);
      vectors++;
      if ({mem_en, mem_we, mem_addr, mem_be, mem_wdata, ack0, ack1} !== {1'b1, 1'b1, 20'h00010, 4'hF, 32'hDEADBEEF, 2'b00}) begin
         miscompares++;
         $display("FAIL write_cmd: got en=%b we=%b addr=%h be=%h wd=%h ack=%b%b expected 1 1 00010 f deadbeef 00",
                  mem_en, mem_we, mem_addr, mem_be, mem_wdata, ack0, ack1);
      end
      @(negedge clk);
      vectors++;
      if ({ack0, ack1, mem_en} !== 3'b100) begin
         miscompares++;
         $display("FAIL write_ack: got ack0=%b ack1=%b en=%b expected 1 0 0", ack0, ack1, mem_en);
      end
      e = exp_q.pop_front();
      vectors++;
      if (e.port != 0 || rdata0 !== rdata0_m) begin
         miscompares++;
         $display("FAIL write_sb: got port=0 rdata0=%h expected port=%0d rdata0=%h", rdata0, e.port, rdata0_m);
      end
      req0 = 1'b0;
      @(negedge clk);
      vectors++;
      if ({ack0, mem_en, mem_we, mem_addr} !== {1'b0, 1'b0, 1'b1, 20'h00010}) begin
         miscompares++;
         $display("FAIL write_hold: got ack0=%b en=%b we=%b addr=%h expected 0 0 1 00010", ack0, mem_en, mem_we, mem_addr);
      end
      $display("txn write port0 addr=00010 data=deadbeef: checked");
   endtask

   task automatic test_read_busy();
      exp_t e;
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b0; addr1 = 20'h00010; be1 = 4'hF;
      mem_busy = 1'b1; mem_rdata = 32'h12345678;
      exp_q.push_back('{1, 1'b1, 32'h12345678});
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         vectors++;
         if ({mem_en, mem_we, mem_addr, ack0, ack1} !== {1'b1, 1'b0, 20'h00010, 2'b00}) begin
            miscompares++;
            $display("FAIL read_busy_c%0d: got en=%b we=%b addr=%h ack=%b%b expected 1 0 00010 00",
                     c, mem_en, mem_we, mem_addr, ack0, ack1);
         end
         if (c == 4) mem_busy = 1'b0;
      end
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({ack1, ack0, mem_en} !== 3'b100 || e.port != 1 || rdata1 !== e.data) begin
         miscompares++;
         $display("FAIL read_ack: got ack1=%b ack0=%b en=%b rdata1=%h expected 1 0 0 port=%0d rdata1=%h",
                  ack1, ack0, mem_en, rdata1, e.port, e.data);
      end
      rdata1_m = e.data;
      req1 = 1'b0; mem_rdata = 32'hFFFF0000;
      @(negedge clk);
      vectors++;
      if ({ack1, rdata1} !== {1'b0, rdata1_m}) begin
         miscompares++;
         $display("FAIL read_hold: got ack1=%b rdata1=%h expected 0 %h", ack1, rdata1, rdata1_m);
      end
      $display("txn read port1 busy=3 data=%h: checked", rdata1_m);
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      int          port, cyc;
      bit          dual;
      int          seq[4];
      logic [31:0] obs;
`ifdef SRAM_ARB_RR_EN
      seq = '{0, 1, 0, 1};
`else
      seq = '{0, 0, 0, 0};
`endif
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00100; be0 = 4'hF;
      req1 = 1'b1; we1 = 1'b0; addr1 = 20'h00200; be1 = 4'hF;
      mem_busy = 1'b0;
      for (int k = 0; k <= 4; k++) begin
         if (k == 4) req0 = 1'b0;
         mem_rdata = 32'hCAFE0000 + k;
         exp_q.push_back('{(k == 4) ? 1 : seq[k], 1'b1, 32'hCAFE0000 + k});
         wait_ack(20, port, cyc, dual);
         e   = exp_q.pop_front();
         obs = (port == 1) ? rdata1 : rdata0;
         vectors++;
         if (port != e.port || obs !== e.data || dual || cyc != ((k == 0) ? 2 : 3)) begin
            miscompares++;
            $display("FAIL b2b_%0d: got port=%0d rdata=%h dual=%b latency=%0d expected port=%0d rdata=%h dual=0 latency=%0d",
                     k, port, obs, dual, cyc, e.port, e.data, (k == 0) ? 2 : 3);
         end
         if (port == 0) rdata0_m = obs;
         if (port == 1) rdata1_m = obs;
         $display("txn b2b %0d: ack port %0d rdata=%h", k, port, obs);
      end
      req1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_addr_change();
      exp_t e;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00020; be0 = 4'hF;
      mem_busy = 1'b1; mem_rdata = 32'h0BADF00D;
      exp_q.push_back('{0, 1'b1, 32'h0BADF00D});
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         vectors++;
         if ({mem_en, mem_we, mem_addr, mem_be} !== {1'b1, 1'b0, 20'h00020, 4'hF}) begin
            miscompares++;
            $display("FAIL addr_latch_c%0d: got en=%b we=%b addr=%h be=%h expected 1 0 00020 f",
                     c, mem_en, mem_we, mem_addr, mem_be);
         end
         if (c == 1) begin
            addr0 = 20'h3FFFF; we0 = 1'b1; be0 = 4'h3; wdata0 = 32'h55555555;
         end
         if (c == 3) mem_busy = 1'b0;
      end
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({ack0, mem_addr, rdata0} !== {1'b1, 20'h00020, e.data}) begin
         miscompares++;
         $display("FAIL addr_done: got ack0=%b addr=%h rdata0=%h expected 1 00020 %h", ack0, mem_addr, rdata0, e.data);
      end
      rdata0_m = e.data;
      req0 = 1'b0; we0 = 1'b0;
      @(negedge clk);
      $display("txn addr change during access: checked");
   endtask

   task automatic test_max_addr();
      exp_t e;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 20'hFFFFF; be0 = 4'h1; wdata0 = 32'h000000AB; mem_busy = 1'b0;
      exp_q.push_back('{0, 1'b0, 32'h0});
      @(negedge clk);
      vectors++;
      if ({mem_en, mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 1'b1, 20'hFFFFF, 4'h1, 32'h000000AB}) begin
         miscompares++;
         $display("FAIL max_addr: got en=%b we=%b addr=%h be=%h wd=%h expected 1 1 fffff 1 000000ab",
                  mem_en, mem_we, mem_addr, mem_be, mem_wdata);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (ack0 !== 1'b1 || e.port != 0 || rdata0 !== rdata0_m) begin
         miscompares++;
         $display("FAIL max_ack: got ack0=%b rdata0=%h expected 1 %h", ack0, rdata0, rdata0_m);
      end
      req0 = 1'b0;
      @(negedge clk);
      $display("txn max addr fffff be=1: checked");
   endtask

   task automatic test_reset_abort();
      exp_t        e;
      int          port, cyc;
      bit          dual;
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b0; addr1 = 20'h00040; be1 = 4'hF;
      mem_busy = 1'b1; mem_rdata = 32'h5A5A5A5A;
      @(negedge clk);
      vectors++;
      if (mem_en !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_pre: got en=%b expected 1", mem_en);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if ({mem_en, ack0, ack1, rdata0, rdata1, mem_addr} !== '0) begin
         miscompares++;
         $display("FAIL abort_rst: got en=%b ack=%b%b rd0=%h rd1=%h addr=%h expected all zero",
                  mem_en, ack0, ack1, rdata0, rdata1, mem_addr);
      end
      rdata0_m = '0; rdata1_m = '0;
      @(negedge clk);
      rst = 1'b0; mem_busy = 1'b0;
      exp_q.push_back('{1, 1'b1, 32'h5A5A5A5A});
      wait_ack(20, port, cyc, dual);
      e = exp_q.pop_front();
      vectors++;
      if (port != e.port || rdata1 !== e.data || cyc != 2 || dual) begin
         miscompares++;
         $display("FAIL abort_reissue: got port=%0d rdata1=%h latency=%0d expected port=%0d rdata1=%h latency=2",
                  port, rdata1, cyc, e.port, e.data);
      end
      req1 = 1'b0;
      @(negedge clk);
      $display("txn reset abort then reissue port1: checked");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read_busy();
      test_back_to_back();
      test_addr_change();
      test_max_addr();
      test_reset_abort();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
